// File: rtl/cbd_if.sv
// cbd_if: sampler bus; byte_array/len driven by the master (PRF side), f driven by the slave (cbd)
interface cbd_if #(
  parameter int N      = 256,
  parameter int COEF_W = 3
);
  logic [7:0]               byte_array [N];
  logic [$clog2(N):0]       len;
  logic signed [COEF_W-1:0] f          [N];
  modport master (output byte_array, len, input f);
  modport slave  (input byte_array, len, output f);
endinterface

// File: rtl/cbd.sv
// cbd: CBD_eta sampler; ports clk, reset (sync active-high), bus.byte_array/bus.len in, bus.f registered signed coefficients out
module cbd #(
  parameter int ETA    = 2,
  parameter int N      = 256,
  parameter int COEF_W = 3
) (
  input logic  clk,
  input logic  reset,
  cbd_if.slave bus
);
  localparam int NB = 2 * ETA * N;
  localparam int LW = $clog2(N) + 1;
  localparam int SW = $clog2(ETA + 1);
  logic [NB-1:0]            bits;
  logic signed [COEF_W-1:0] f_d [N];
  logic signed [COEF_W-1:0] f_q [N];
  for (genvar k = 0; k < NB / 8; k++) begin : g_b
    assign bits[8*k +: 8] = (LW'(k) < bus.len) ? bus.byte_array[k] : '0;
  end
  for (genvar i = 0; i < N; i++) begin : g_c
    logic [SW-1:0] a_sum, b_sum;
    always_comb begin
      a_sum = '0;
      b_sum = '0;
      for (int j = 0; j < ETA; j++) begin
        a_sum = a_sum + SW'(bits[2*ETA*i + j]);
        b_sum = b_sum + SW'(bits[2*ETA*i + ETA + j]);
      end
    end
    assign f_d[i] = COEF_W'(a_sum) - COEF_W'(b_sum);
  end
  always_ff @(posedge clk) begin
    if (reset) f_q <= '{default: '0};
    else       f_q <= f_d;
  end
  assign bus.f = f_q;
endmodule

// File: tb/tb_cbd.sv
// tb_cbd: table-driven and random scoreboard bench for the cbd sampler
module tb_cbd;
  localparam int N = 256;
  localparam int W = 3;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  cbd_if #(.N(N), .COEF_W(W)) bus ();
  cbd #(.ETA(2), .N(N), .COEF_W(W)) dut (.clk(clk), .reset(reset), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [W*N-1:0] exp_q [$];
  string          name_q [$];
  typedef struct {
    string      name;
    logic [7:0] fill;
    int         len;
    int         e0;
    int         e1;
    int         cut;
  } vec_t;
  vec_t tbl [9];
  function automatic bit ref_bit(int n);
    int k = n / 8;
    return (k < int'(bus.len) && k < 128) ? bus.byte_array[k][n % 8] : 1'b0;
  endfunction
  function automatic logic [W*N-1:0] ref_f();
    logic [W*N-1:0] r = '0;
    for (int i = 0; i < N; i++) begin
      int a = int'(ref_bit(4*i)) + int'(ref_bit(4*i + 1));
      int c = int'(ref_bit(4*i + 2)) + int'(ref_bit(4*i + 3));
      r[W*i +: W] = W'(a - c);
    end
    return r;
  endfunction
  function automatic logic [W*N-1:0] pat_f(int e0, int e1, int cut);
    logic [W*N-1:0] r = '0;
    for (int i = 0; i < cut; i++) r[W*i +: W] = W'((i % 2 == 0) ? e0 : e1);
    return r;
  endfunction
  task automatic drive(logic [7:0] fill, int len, bit rand_lo, bit rand_hi);
    for (int k = 0; k < N; k++)
      bus.byte_array[k] = ((k < 128) ? rand_lo : rand_hi) ? 8'($urandom) : fill;
    bus.len = 9'(len);
  endtask
  task automatic push(string name, logic [W*N-1:0] e);
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask
  task automatic check();
    logic [W*N-1:0] got, e;
    string nm;
    @(posedge clk);
    #1;
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    for (int i = 0; i < N; i++) got[W*i +: W] = bus.f[i];
    checks++;
    if (got !== e) begin
      int idx = 0;
      errors++;
      for (int i = N - 1; i >= 0; i--) if (got[W*i +: W] !== e[W*i +: W]) idx = i;
      $display("FAIL %s: f[%0d] got %0d want %0d", nm, idx,
               $signed(got[W*idx +: W]), $signed(e[W*idx +: W]));
    end
  endtask
  initial begin
    tbl[0] = '{"p33",    8'h33, 256,  2,  2, 256};
    tbl[1] = '{"pcc",    8'hCC, 256, -2, -2, 256};
    tbl[2] = '{"p00",    8'h00, 256,  0,  0, 256};
    tbl[3] = '{"pff",    8'hFF, 256,  0,  0, 256};
    tbl[4] = '{"len64",  8'h33,  64,  2,  2, 128};
    tbl[5] = '{"len0",   8'h33,   0,  2,  2,   0};
    tbl[6] = '{"len300", 8'hCC, 300, -2, -2, 256};
    tbl[7] = '{"p1e",    8'h1E, 256, -1,  1, 256};
    tbl[8] = '{"len10",  8'h1E,  10, -1,  1,  20};
    reset = 1'b1;
    drive(8'h00, 256, 1'b1, 1'b1);
    push("reset", '0);
    check();
    @(negedge clk);
    reset = 1'b0;
    begin
      int e6 [6] = '{0, -1, 1, 0, 1, 1};
      logic [W*N-1:0] e = '0;
      drive(8'h00, 256, 1'b0, 1'b0);
      bus.byte_array[0] = 8'd239;
      bus.byte_array[1] = 8'd146;
      bus.byte_array[2] = 8'd18;
      for (int i = 0; i < 6; i++) e[W*i +: W] = W'(e6[i]);
      push("vec239", e);
      check();
    end
    for (int t = 0; t < 9; t++) begin
      @(negedge clk);
      drive(tbl[t].fill, tbl[t].len, 1'b0, 1'b1);
      push(tbl[t].name, pat_f(tbl[t].e0, tbl[t].e1, tbl[t].cut));
      check();
    end
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      drive(8'h00, (t % 3 == 0) ? int'($urandom_range(0, 300)) : 256, 1'b1, 1'b1);
      reset = (t == 6);
      push(reset ? "midreset" : "random", reset ? '0 : ref_f());
      check();
    end
    @(negedge clk);
    reset = 1'b0;
    drive(8'h00, 256, 1'b1, 1'b1);
    push("resume", ref_f());
    check();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
